// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, requester ids and
// the default starvation limit.
package mem_arb_pkg;

  localparam int STARVE_MAX_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  // Bits needed to hold 0..max_val inclusive; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational fetch/data winner selection; with MEM_ARB_STARVE_GUARD_EN a saturating
// counter of data grants made while fetch waits lets fetch win once it reaches STARVE_MAX.
module arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_if_req,
  input  logic    i_dm_req,
  input  logic    i_grant,
  output req_id_t o_winner
);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = cnt_width(STARVE_MAX);

  logic [CW-1:0] r_starve_cnt;
  logic          w_starved;

  assign w_starved = (r_starve_cnt == CW'(STARVE_MAX));

  always_comb begin
    o_winner = REQ_IF;
    if (i_dm_req && !(i_if_req && w_starved)) begin
      o_winner = REQ_DM;
    end
  end

  // Only data grants that overtake a waiting fetch count toward starvation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (i_grant) begin
      if ((o_winner == REQ_IF) || !i_if_req) begin
        r_starve_cnt <= '0;
      end else if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end
    end
  end
`else
  logic w_unused;

  assign w_unused = &{1'b0, clk, rst, i_grant, (STARVE_MAX > 0)};

  always_comb begin
    o_winner = i_dm_req ? REQ_DM : REQ_IF;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data, one transaction in flight; load/fetch
// valid 3 cycles after an IDLE grant, store 2, stretched by mem_ready/mem_rvalid (MEM_ARB_STARVE_GUARD_EN).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  req_id_t     w_winner;
  req_id_t     r_owner;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        w_grant;
  logic        w_capture;

  assign w_grant = (r_state == ST_IDLE) && (if_req || dm_req);

  arb_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb_select (
    .clk      (clk),
    .rst      (rst),
    .i_if_req (if_req),
    .i_dm_req (dm_req),
    .i_grant  (w_grant),
    .o_winner (w_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // mem_ready and mem_rvalid are only looked at in the state that expects them.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    if_valid    = 1'b0;
    dm_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req = 1'b1;
        mem_we  = r_we;
        if (mem_ready) begin
          w_state_nxt = r_we ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if_valid    = (r_owner == REQ_IF);
        dm_valid    = (r_owner == REQ_DM);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request payload is frozen at grant so the memory sees it stable through ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= REQ_IF;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_winner;
        if (w_winner == REQ_DM) begin
          r_addr  <= dm_addr;
          r_we    <= dm_we;
          r_wdata <= dm_wdata;
        end else begin
          r_addr  <= if_addr;
          r_we    <= 1'b0;
          r_wdata <= '0;
        end
      end
      if (w_capture) begin
        if (r_owner == REQ_DM) begin
          r_dm_rdata <= mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_stall  = if_req && !if_valid;
  assign dm_stall  = dm_req && !dm_valid;

  a_valid_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(if_valid && dm_valid));

  a_issue_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_req && !mem_ready) |=> (mem_req && $stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed latency/priority/reset cases, then random
// fetch and data traffic against a randomly stalling memory, all checked by one monitor.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int STARVE_MAX = 3;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_valid, if_stall, dm_valid, dm_stall;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Memory image: fetch region below 0x1_0000, data region at 0x1_xxxx.
  function automatic logic [31:0] mem_init(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return a[16] ? (~a ^ 32'h5A5A_0000) : ((a * 32'h9E37_79B1) ^ 32'h0000_1234);
  endfunction

  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] resp_mem [logic [31:0]];
  logic [31:0] dm_last = 32'h0;

  typedef struct packed { logic is_store; logic [31:0] data; } exp_t;
  exp_t if_q[$];
  exp_t dm_q[$];
  bit   gl[$];
  bit   hist[$];

  int rdy_lat_fix = 0;
  int rv_dly_fix  = 0;
  bit stray_en    = 1'b0;

  // ---------------- memory responder ----------------
  initial begin : responder
    bit acc, acc_we, rv_taken, pend;
    logic [31:0] acc_a, acc_d, pend_a;
    int dly, held, lat;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    pend = 0; held = 0; dly = 0; lat = 0; pend_a = '0;
    forever begin
      @(negedge clk);
      acc      = mem_req && mem_ready;
      acc_we   = mem_we;
      acc_a    = mem_addr;
      acc_d    = mem_wdata;
      rv_taken = mem_rvalid && pend;
      @(posedge clk); #1;
      if (rv_taken) pend = 0;
      if (acc) begin
        if (acc_we) resp_mem[acc_a] = acc_d;
        else begin
          pend = 1; pend_a = acc_a;
          dly = (rv_dly_fix >= 0) ? rv_dly_fix : int'($urandom_range(0, 4));
        end
      end
      if (!mem_req) held = 0;
      if (mem_req && held == 0) lat = (rdy_lat_fix >= 0) ? rdy_lat_fix : int'($urandom_range(0, 3));
      mem_ready = mem_req ? (held >= lat) : (stray_en && $urandom_range(0, 3) == 0);
      if (mem_req) held++;
      if (pend && dly == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = resp_mem.exists(pend_a) ? resp_mem[pend_a] : mem_init(pend_a);
      end else begin
        if (pend) dly--;
        mem_rvalid = stray_en && !pend && ($urandom_range(0, 3) == 0);
        mem_rdata  = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        p_mem_req, p_if_req, p_dm_req, p_dm_we, p_if_vld, p_dm_vld;
  logic [31:0] p_if_addr, p_dm_addr, p_dm_wdata;
  logic [31:0] iss_addr, iss_wdata;
  logic        iss_we;
  int          iss_len = 0;
  bit          m_exp_dm, m_starved;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      hist.delete();
      p_mem_req = 0; p_if_req = 0; p_dm_req = 0; p_dm_we = 0; p_if_vld = 0; p_dm_vld = 0;
    end else begin
      if (mem_req && !p_mem_req) begin
        m_starved = (hist.size() >= STARVE_MAX);
        for (int i = 0; i < STARVE_MAX; i++)
          if (i < hist.size() && !hist[hist.size() - 1 - i]) m_starved = 1'b0;
        if (!p_dm_req)      m_exp_dm = 1'b0;
        else if (!p_if_req) m_exp_dm = 1'b1;
        else                m_exp_dm = !(GUARD && m_starved);
        check("grant winner is data", {31'd0, mem_addr[16]}, {31'd0, m_exp_dm});
        check("grant address", mem_addr, m_exp_dm ? p_dm_addr : p_if_addr);
        check("grant we", {31'd0, mem_we}, {31'd0, m_exp_dm && p_dm_we});
        if (m_exp_dm && p_dm_we) check("grant wdata", mem_wdata, p_dm_wdata);
        hist.push_back(m_exp_dm && p_if_req);
        gl.push_back(mem_addr[16]);
        iss_len = 1; iss_addr = mem_addr; iss_we = mem_we; iss_wdata = mem_wdata;
      end else if (mem_req) begin
        iss_len++;
        check("issue addr stable", mem_addr, iss_addr);
        check("issue wdata stable", mem_wdata, iss_wdata);
        check("issue we stable", {31'd0, mem_we}, {31'd0, iss_we});
      end
      if (if_valid) begin
        check("if_valid one cycle", {31'd0, p_if_vld}, 32'd0);
        if (if_q.size() == 0) fail_now("unexpected if_valid");
        else begin m_e = if_q.pop_front(); check("if_rdata", if_rdata, m_e.data); end
      end
      if (dm_valid) begin
        check("dm_valid one cycle", {31'd0, p_dm_vld}, 32'd0);
        if (dm_q.size() == 0) fail_now("unexpected dm_valid");
        else begin
          m_e = dm_q.pop_front();
          check(m_e.is_store ? "dm_rdata held over store" : "dm_rdata load", dm_rdata, m_e.data);
        end
      end
      check("if_stall", {31'd0, if_stall}, {31'd0, if_req && !if_valid});
      check("dm_stall", {31'd0, dm_stall}, {31'd0, dm_req && !dm_valid});
      p_mem_req = mem_req; p_if_vld = if_valid; p_dm_vld = dm_valid;
      p_if_req = if_req; p_dm_req = dm_req; p_dm_we = dm_we;
      p_if_addr = if_addr; p_dm_addr = dm_addr; p_dm_wdata = dm_wdata;
    end
  end

  // ---------------- requester tasks (called at posedge+1) ----------------
  task automatic fetch_op(input logic [31:0] a, output int lat);
    int t0, n;
    if_req = 1'b1; if_addr = a;
    if_q.push_back('{1'b0, mem_init(a)});
    t0 = cyc; n = 0; lat = -1;
    forever begin
      @(negedge clk);
      if (if_valid) begin lat = cyc - t0; break; end
      if (++n > 300) begin fail_now("fetch wait timeout"); break; end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dm_op(input logic we, input logic [31:0] a, input logic [31:0] d, output int lat);
    int t0, n;
    logic [31:0] v;
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
    if (we) begin
      dm_q.push_back('{1'b1, dm_last});
      ref_mem[a] = d;
    end else begin
      v = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
      dm_last = v;
      dm_q.push_back('{1'b0, v});
    end
    t0 = cyc; n = 0; lat = -1;
    forever begin
      @(negedge clk);
      if (dm_valid) begin lat = cyc - t0; break; end
      if (++n > 300) begin fail_now("data wait timeout"); break; end
    end
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, " if_valid"}, {31'd0, if_valid}, 32'd0);
    check({tag, " dm_valid"}, {31'd0, dm_valid}, 32'd0);
    check({tag, " mem_req"},  {31'd0, mem_req},  32'd0);
    check({tag, " mem_we"},   {31'd0, mem_we},   32'd0);
    check({tag, " mem_addr"}, mem_addr, 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    check({tag, " if_rdata"}, if_rdata, 32'd0);
    check({tag, " dm_rdata"}, dm_rdata, 32'd0);
    check({tag, " stalls"}, {30'd0, if_stall, dm_stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int la, lb, n0;
    bit dm_done;
    rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge clk); #1;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    fetch_op(32'h10, la);
    check("fetch latency", la, 3);
    check("fetch 0x10 rdata", if_rdata, 32'h0050_0093);

    dm_op(1'b1, 32'h0001_0004, 32'h1234_5678, la);
    check("store latency", la, 2);

    rdy_lat_fix = 2;
    dm_op(1'b1, 32'h0001_0100, 32'hDEAD_BEEF, la);
    check("stalled store mem_req cycles", iss_len, 3);
    check("stalled store latency", la, 4);
    rdy_lat_fix = 0;
    dm_op(1'b0, 32'h0001_0100, 32'h0, la);
    check("load latency", la, 3);
    check("load readback", dm_rdata, 32'hDEAD_BEEF);

    n0 = gl.size();
    fork
      fetch_op(32'h20, la);
      dm_op(1'b0, 32'h0001_0004, 32'h0, lb);
    join
    check("simultaneous: first grant data", {31'd0, gl[n0]}, 32'd1);
    check("simultaneous: second grant fetch", {31'd0, gl[n0 + 1]}, 32'd0);
    check("simultaneous: fetch latency", la, 7);
    check("simultaneous: data latency", lb, 3);

    n0 = gl.size();
    dm_done = 1'b0;
    fork
      begin
        int l;
        for (int i = 0; i < 8; i++) dm_op(1'b0, 32'h0001_0000 + 32'(i * 4), 32'h0, l);
        dm_done = 1'b1;
      end
      begin
        int l, k;
        k = 0;
        while (!dm_done) begin fetch_op(32'h40 + 32'(k * 4), l); k++; end
      end
    join
    for (int i = 0; i < 8; i++)
      check("contended grant order", {31'd0, gl[n0 + i]}, {31'd0, !(GUARD && (i % 4 == 3))});

    rv_dly_fix = 5;
    dm_op(1'b0, 32'h0001_0008, 32'h0, la);
    check("slow load latency", la, 8);
    rv_dly_fix = 6;

    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0001_000C;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1; dm_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    dm_last = 32'h0;
    repeat (10) @(posedge clk); #1;
    check_idle("after mid-wait reset");
    rv_dly_fix = 0;
    fetch_op(32'h30, la);
    check("post-reset fetch latency", la, 3);

    stray_en = 1'b1; rdy_lat_fix = -1; rv_dly_fix = -1;
    fork
      begin
        int l;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          fetch_op({22'd0, 8'($urandom_range(0, 255)), 2'b00}, l);
        end
      end
      begin
        int l;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          dm_op(1'($urandom_range(0, 1)), 32'h0001_0000 | (32'($urandom_range(0, 15)) << 2), $urandom, l);
        end
      end
    join
    repeat (5) @(posedge clk); #1;
    check("fetch scoreboard drained", if_q.size(), 0);
    check("data scoreboard drained", dm_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
